// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch requester
// (PC side) and the data load/store requester (datapath side). Accesses are
// serialised with a round-robin grant. Address, write data and strobes are
// held stable for MEM_LAT cycles, and read data is returned in a register
// together with a one-cycle done pulse. While a fetch is outstanding, a stall
// is driven to the PC enable logic.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_if_req     fetch request, held high until o_if_done
//   i_if_addr    fetch address, stable while i_if_req is high
//   o_if_done    one-cycle pulse: fetch complete, o_if_rdata valid
//   o_if_rdata   registered instruction word
//   i_d_req      data request, held high until o_d_done
//   i_d_we       1 = store, 0 = load
//   i_d_addr     data address
//   i_d_wdata    store data
//   o_d_done     one-cycle pulse: data access complete
//   o_d_rdata    registered load data
//   o_mem_addr   address to memory (zero outside an access)
//   o_mem_wdata  write data to memory (zero outside an access)
//   o_mem_read   memory read strobe
//   o_mem_write  memory write strobe
//   i_mem_rdata  read data from memory
//   o_pc_stall   high while a fetch is requested and not yet done
//
// MEM_LAT must lie in 1..15 (the hold counter is 4 bits wide).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_done,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_pc_stall
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t              r_state;
  state_t              w_nextState;
  owner_t              r_owner;
  logic                r_fetchFirst;
  logic [3:0]          r_latCnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [DATA_W-1:0]   r_ifRdata;
  logic [DATA_W-1:0]   r_dRdata;

  logic                w_anyReq;
  logic                w_grantFetch;
  logic                w_inAccess;
  logic                w_inResp;

  // Fetch wins when it is alone, or when both ask and it is fetch's turn.
  assign w_anyReq     = i_if_req | i_d_req;
  assign w_grantFetch = i_if_req & (~i_d_req | r_fetchFirst);
  assign w_inAccess   = (r_state == ST_ACCESS);
  assign w_inResp     = (r_state == ST_RESP);

  // State register; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // RESP always falls back to IDLE, so every access costs MEM_LAT+2 cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_anyReq) w_nextState = ST_ACCESS;
      ST_ACCESS: if (r_latCnt == 4'd0) w_nextState = ST_RESP;
      ST_RESP:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Grant capture, hold counter and read-data capture. Fetches register zero
  // write data and a cleared write enable so they can never strobe a write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner      <= OWN_DATA;
      r_fetchFirst <= 1'b0;
      r_latCnt     <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_ifRdata    <= '0;
      r_dRdata     <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_anyReq) begin
          r_owner      <= w_grantFetch ? OWN_FETCH : OWN_DATA;
          r_fetchFirst <= ~w_grantFetch;
          r_latCnt     <= LAT_LOAD;
          r_addr       <= w_grantFetch ? i_if_addr : i_d_addr;
          r_wdata      <= w_grantFetch ? '0 : i_d_wdata;
          r_we         <= ~w_grantFetch & i_d_we;
        end
      end else if (r_state == ST_ACCESS) begin
        if (r_latCnt != 4'd0) begin
          r_latCnt <= r_latCnt - 4'd1;
        end else if (r_owner == OWN_FETCH) begin
          r_ifRdata <= i_mem_rdata;
        end else if (!r_we) begin
          r_dRdata <= i_mem_rdata;
        end
      end
    end
  end

  // Memory-side outputs come straight from registers gated by ACCESS, so
  // they drop the moment reset clears the state register.
  assign o_mem_addr  = w_inAccess ? r_addr : '0;
  assign o_mem_wdata = w_inAccess ? r_wdata : '0;
  assign o_mem_read  = w_inAccess & ((r_owner == OWN_FETCH) | ~r_we);
  assign o_mem_write = w_inAccess & (r_owner == OWN_DATA) & r_we;

  assign o_if_done   = w_inResp & (r_owner == OWN_FETCH);
  assign o_d_done    = w_inResp & (r_owner == OWN_DATA);
  assign o_if_rdata  = r_ifRdata;
  assign o_d_rdata   = r_dRdata;

  // Combinational so the PC is released in the very cycle the fetch is done.
  assign o_pc_stall  = i_if_req & ~o_if_done;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single unified memory port between the instruction-fetch requester (PC side) and the data load/store requester (ALU/register side). It serialises accesses with a round-robin grant and holds each access stable for a fixed memory latency. It returns registered read data with a one-cycle done pulse and drives a stall to the PC enable logic while a fetch is outstanding. It sits between the PC/datapath and the memory block.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width of read/write paths
MEM_LAT, 2, cycles the memory strobes/address are held per access; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  ADDR_W  fetch address; stable while if_req high
if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  registered instruction word
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = store, 0 = load; stable while d_req high
d_addr  in  ADDR_W  data address; stable while d_req high
d_wdata  in  DATA_W  store data; stable while d_req high
d_done  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  registered load data
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  DATA_W  read data from memory
pc_stall  out  1  high while a fetch is requested and not yet done

Behaviour:
- Reset (rst=0, async): state=IDLE, owner=DATA, fetch_first=0, lat counter=0; if_done, d_done, mem_read, mem_write=0; mem_addr, mem_wdata, if_rdata, d_rdata=0. Reset mid-access abandons the access: no done pulse, and the strobes drop immediately.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. RESP always returns to IDLE; there is no back-to-back skip.
- IDLE: at a rising edge with any request, register owner, address, wdata and we; go to ACCESS with counter=MEM_LAT-1. No request: stay in IDLE.
- Arbitration in IDLE:
  - Only one request: that requester wins.
  - Both requests: data wins if fetch_first=0, fetch wins if fetch_first=1.
  - On every grant, fetch_first <= (owner==DATA), giving strict alternation under contention. The first contention after reset goes to data.
- ACCESS: mem_addr and mem_wdata are driven from registers.
  - mem_read = owner==FETCH or d_we==0.
  - mem_write = owner==DATA and d_we==1.
  - Strobes are held for exactly MEM_LAT cycles. The counter decrements each cycle; at counter==0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP: strobes=0, mem_addr and mem_wdata return to 0, and the owner's done=1 for exactly this cycle.
  - A store leaves d_rdata unchanged.
  - The non-owner's rdata is never modified.
- Latency: request sampled at edge k gives ACCESS cycles k+1..k+MEM_LAT and done in cycle k+MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- pc_stall = if_req & ~if_done (combinational), so the PC advances in the done cycle.
- A request dropped mid-access violates the protocol; the arbiter still completes the access and pulses done.
- A requester that keeps req high after done is treated as a new request in the following IDLE cycle.
- mem_read and mem_write are never high together; done pulses never coincide.

Test Plan:
- Reset: hold rst=0, apply random requests -> all outputs 0; release -> IDLE, no strobes until a request arrives.
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x40, memory returns 0x8C220004 -> mem_read=1 with mem_addr=0x40 for 2 cycles; if_done pulses 3 cycles after sampling with if_rdata=0x8C220004; pc_stall=1 until that cycle.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_write=1 for MEM_LAT cycles with those values and mem_read=0; d_done pulses; d_rdata keeps its prior value.
- Contention: if_req and d_req held high continuously from reset -> grants alternate D,F,D,F; each done follows MEM_LAT+2 cycles after the previous one; no starvation over 20 accesses.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 with a load of 0x12345678 from 0x200 -> strobe width equals MEM_LAT; d_rdata=0x12345678 in the d_done cycle.
- Mid-access reset: assert rst=0 in the second ACCESS cycle -> strobes drop asynchronously; no done pulse; after release, a pending if_req is served normally.
